// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if
// Groups the signals that connect the fetch unit to the next-PC logic,
// decode and instruction memory.
//   master : the fetch unit. It drives PC/instr/instr_valid/exc_adel, the
//            imem request and the state_dbg debug bit.
//   slave  : the environment (next-PC logic, decode, memory).
// Handshakes:
//   - imem_req/imem_ack: imem_req is held while a fetch is outstanding.
//     imem_ack is a single-cycle response that carries imem_rdata. A request
//     may be dropped (on reset) without an ack.
//   - instr_valid/advance: decode pulses advance while instr_valid=1 to
//     retire the instruction. PC_next is taken on that same edge.
//     advance while instr_valid=0 is ignored.
interface pc_fetch_unit_if;
  logic [31:0] PC_next;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exc_adel;
  logic        state_dbg;  // 0 = FETCH, 1 = HOLD

  modport master (
    input  PC_next, advance, imem_ack, imem_rdata,
    output imem_req, imem_addr, PC, instr, instr_valid, exc_adel, state_dbg
  );

  modport slave (
    output PC_next, advance, imem_ack, imem_rdata,
    input  imem_req, imem_addr, PC, instr, instr_valid, exc_adel, state_dbg
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Holds the architectural PC and fetches the instruction word at that PC.
// It presents the word to decode and loads PC_next when decode retires the
// instruction. An illegal PC raises exc_adel and never reaches memory. An
// illegal PC is one that is misaligned or outside [IMEM_BASE, IMEM_LIMIT].
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears all state
//   bus   : pc_fetch_unit_if.master. It carries:
//             PC_next, advance
//             imem_req, imem_addr, imem_ack, imem_rdata
//             PC, instr, instr_valid, exc_adel
//             state_dbg (debug)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0000_6FFC
) (
  input  logic            clk,
  input  logic            reset,
  pc_fetch_unit_if.master bus
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_nx;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        adel_q;
  logic        bad;

  // Control strobes computed by the next-state logic
  logic        take_data;  // latch imem_rdata, go to HOLD
  logic        take_adel;  // latch the address error, go to HOLD
  logic        take_next;  // load PC_next, go back to FETCH

  // Unsigned compares. A misaligned PC is rejected even when it is in range.
  assign bad = (pc_q[1:0] != 2'b00) | (pc_q < IMEM_BASE) | (pc_q > IMEM_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.imem_req = 1'b0;
    take_data    = 1'b0;
    take_adel    = 1'b0;
    take_next    = 1'b0;
    case (state)
      FETCH: begin
        // advance is ignored here. imem_ack only counts for a legal PC.
        if (bad) begin
          take_adel = 1'b1;
          state_nx  = HOLD;
        end else begin
          bus.imem_req = 1'b1;
          if (bus.imem_ack) begin
            take_data = 1'b1;
            state_nx  = HOLD;
          end
        end
      end
      HOLD: begin
        // A stale imem_ack here is dropped. Only advance acts.
        if (bus.advance) begin
          take_next = 1'b1;
          state_nx  = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else begin
      if (take_data) begin
        instr_q <= bus.imem_rdata;
        valid_q <= 1'b1;
        adel_q  <= 1'b0;
      end else if (take_adel) begin
        instr_q <= 32'h0;  // nop stands in for the faulting instruction
        valid_q <= 1'b1;
        adel_q  <= 1'b1;
      end else if (take_next) begin
        // All 32 bits are loaded as given. The alignment and range check
        // happens in the FETCH that follows.
        pc_q    <= bus.PC_next;
        valid_q <= 1'b0;
        adel_q  <= 1'b0;
      end
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.PC          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.exc_adel    = adel_q;
  assign bus.state_dbg   = state;

endmodule
